crc_gen_param: RTL



---
 rtl/crc_gen_param_if.sv | 65 ++++++
 rtl/crc_gen_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/crc_gen_param_if.sv
`default_nettype none
// ============================================================================
// Module      : crc_gen_param_if
// Description : Beat/result bundle between a frame source and crc_gen_param.
//               The master side drives payload beats and framing. The slave
//               side, which is the CRC generator, returns ready, the result
//               strobe, the serial append stream and the abort pulse.
//               crc_err is present only when CRC_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface crc_gen_param_if #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 1
) ();

    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              sof;
    logic              eof;
    logic              in_ready;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_valid;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_abort;
`ifdef CRC_CHECK_EN
    logic              crc_err;
`endif

    // Frame source side
    modport master (
`ifdef CRC_CHECK_EN
        input  crc_err,
`endif
        output din_valid,
        output din,
        output sof,
        output eof,
        input  in_ready,
        input  crc_out,
        input  crc_valid,
        input  ser_out,
        input  ser_valid,
        input  frame_abort
    );

    // CRC generator side
    modport slave (
`ifdef CRC_CHECK_EN
        output crc_err,
`endif
        input  din_valid,
        input  din,
        input  sof,
        input  eof,
        output in_ready,
        output crc_out,
        output crc_valid,
        output ser_out,
        output ser_valid,
        output frame_abort
    );

endinterface
`default_nettype wire

// File: rtl/crc_gen_param.sv
`default_nettype none
// ============================================================================
// Module      : crc_gen_param
// Description : Parametrised, frame-aware CRC generator. It takes DATA_W bits
//               per beat (MSB first) with sof/eof framing and strobes a
//               registered result. It can optionally shift the CRC out
//               serially, MSB first, behind the payload.
//               Optional build macro CRC_CHECK_EN adds crc_err, which
//               compares the raw register against CHECK_RESIDUE (RX mode).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_gen_param #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h8005,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter int               DATA_W  = 1,
    parameter int               APPEND  = 1
`ifdef CRC_CHECK_EN
    ,
    parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
`endif
) (
    input  logic           clk,
    input  logic           reset,
    crc_gen_param_if.slave bus
);

    localparam int       c_CNT_W     = $clog2(CRC_W);
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CALC   = 2'd1;
    localparam logic [1:0] c_ST_FIN    = 2'd2;
    localparam logic [1:0] c_ST_APPEND = 2'd3;

    // DATA_W serial shift steps unrolled into one combinational update;
    // data[DATA_W-1] enters the register first.
    function automatic logic [CRC_W-1:0] f_crc_step(
        input logic [CRC_W-1:0]  crc_in,
        input logic [DATA_W-1:0] data
    );
        logic [CRC_W-1:0] v_crc;
        logic             v_fb;
        v_crc = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            v_fb  = v_crc[CRC_W-1] ^ data[i];
            v_crc = {v_crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{v_fb}} & POLY);
        end
        return v_crc;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CRC_W-1:0]   r_crc;
    logic [CRC_W-1:0]   w_crc_seed;
    logic [CRC_W-1:0]   w_crc_next;
    logic [CRC_W-1:0]   r_crc_out;
    logic [CRC_W-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_crc_valid;
    logic               r_frame_abort;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_start;
    logic               w_take;
    logic               w_end;

    // Ready only in the accepting states and forced low while reset is held.
    assign w_in_ready = ~reset & ((r_state == c_ST_IDLE) | (r_state == c_ST_CALC));
    assign w_accept   = bus.din_valid & w_in_ready;
    // A sof beat always (re)starts a frame; in IDLE anything else is dropped.
    assign w_start    = w_accept & bus.sof;
    assign w_take     = w_start | (w_accept & (r_state == c_ST_CALC));
    assign w_end      = w_take & bus.eof;

    assign w_crc_seed = bus.sof ? INIT : r_crc;
    assign w_crc_next = f_crc_step(w_crc_seed, bus.din);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: framing beats steer IDLE/CALC, FIN is one cycle,
    // APPEND lasts until the bit counter reaches zero.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_CALC: begin
                if (w_take) begin
                    w_state_next = bus.eof ? c_ST_FIN : c_ST_CALC;
                end
            end
            c_ST_FIN: begin
                w_state_next = (APPEND != 0) ? c_ST_APPEND : c_ST_IDLE;
            end
            c_ST_APPEND: begin
                if (r_bit_cnt == '0) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Running CRC register, updated on every beat that belongs to a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= INIT;
        end else if (w_take) begin
            r_crc <= w_crc_next;
        end
    end

    // Result and abort strobes, registered straight off the accepted beat so
    // the result is visible in the cycle spent in FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc_out     <= '0;
            r_crc_valid   <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_crc_valid   <= w_end;
            r_frame_abort <= w_start & (r_state == c_ST_CALC);
            if (w_end) begin
                r_crc_out <= w_crc_next ^ XOR_OUT;
            end
        end
    end

    // Append shifter: loaded with the final CRC in FIN, shifted MSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == c_ST_FIN) begin
            r_shift   <= r_crc_out;
            r_bit_cnt <= c_CNT_W'(CRC_W - 1);
        end else if (r_state == c_ST_APPEND) begin
            r_shift   <= {r_shift[CRC_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

`ifdef CRC_CHECK_EN
    logic r_crc_err;

    // Residue compare on the raw register, before XOR_OUT, held with crc_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc_err <= 1'b0;
        end else if (w_end) begin
            r_crc_err <= (w_crc_next != CHECK_RESIDUE);
        end
    end

    assign bus.crc_err = r_crc_err;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.crc_out     = r_crc_out;
    assign bus.crc_valid   = r_crc_valid;
    assign bus.ser_valid   = (r_state == c_ST_APPEND);
    assign bus.ser_out     = (r_state == c_ST_APPEND) & r_shift[CRC_W-1];
    assign bus.frame_abort = r_frame_abort;

endmodule
`default_nettype wire
